// File: rtl/fifo8x9_pkg.sv
// Shared constants and strobe bundle for the 8x9 FIFO control and storage.
package fifo8x9_pkg;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned DATA_W = 9;
    localparam int unsigned CNT_W  = 4;

    // Raw control strobes presented to the storage array.
    typedef struct packed {
        logic wren;
        logic wr_inc;
        logic rden;
        logic rd_inc;
        logic wr_ptr_clr;
        logic rd_ptr_clr;
    } strobe_t;

endpackage

// File: rtl/fifo_occ_counter.sv
// Up/down saturating occupancy counter with synchronous clear and registered flags.
module fifo_occ_counter
    import fifo8x9_pkg::*;
#(
    parameter int unsigned DEPTH_P = DEPTH,
    parameter int unsigned CNT_W_P = CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    input  logic               dec,
    output logic [CNT_W_P-1:0] count,
    output logic               full,
    output logic               empty
);

    localparam logic [CNT_W_P-1:0] CNT_MAX = CNT_W_P'(DEPTH_P);
    localparam logic [CNT_W_P-1:0] CNT_ONE = CNT_W_P'(1);

    logic [CNT_W_P-1:0] count_nxt;

    // Next occupancy; simultaneous inc/dec cancel, limits never crossed.
    always_comb begin
        count_nxt = count;
        if (clr) begin
            count_nxt = '0;
        end else if (inc && !dec && (count != CNT_MAX)) begin
            count_nxt = count + CNT_ONE;
        end else if (dec && !inc && (count != '0)) begin
            count_nxt = count - CNT_ONE;
        end
    end

    // Count and flags registered from the same next value so they always agree.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            count <= count_nxt;
            full  <= (count_nxt == CNT_MAX);
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/fifo8x9_ctrl.sv
// Control stage for the 8x9 FIFO storage: acceptance, strobes, occupancy and error flags.
module fifo8x9_ctrl
    import fifo8x9_pkg::*;
#(
    parameter int unsigned DEPTH_P = DEPTH,
    parameter int unsigned CNT_W_P = CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    output logic               wren,
    output logic               WrInc,
    output logic               rden,
    output logic               RdInc,
    output logic               WrPtrClr,
    output logic               RdPtrClr,
    output logic               full,
    output logic               empty,
    output logic [CNT_W_P-1:0] count,
    output logic               rd_valid,
    output logic               overflow,
    output logic               underflow
);

    logic    clr;
    logic    push_acc;
    logic    pop_acc;
    logic    push_rej;
    logic    pop_rej;
    strobe_t strb;

    // Acceptance decisions from the registered flags; clear blocks everything.
    always_comb begin
        clr      = rst | flush;
        push_acc = push & ~full  & ~clr;
        pop_acc  = pop  & ~empty & ~clr;
        push_rej = push &  full  & ~clr;
        pop_rej  = pop  &  empty & ~clr;
    end

    // Storage strobe decode.
    always_comb begin
        strb            = '0;
        strb.wren       = push_acc;
        strb.wr_inc     = push_acc;
        strb.rden       = pop_acc;
        strb.rd_inc     = pop_acc;
        strb.wr_ptr_clr = clr;
        strb.rd_ptr_clr = clr;
    end

    assign wren     = strb.wren;
    assign WrInc    = strb.wr_inc;
    assign rden     = strb.rden;
    assign RdInc    = strb.rd_inc;
    assign WrPtrClr = strb.wr_ptr_clr;
    assign RdPtrClr = strb.rd_ptr_clr;

    fifo_occ_counter #(
        .DEPTH_P (DEPTH_P),
        .CNT_W_P (CNT_W_P)
    ) u_occ (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (push_acc),
        .dec   (pop_acc),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // DataOut is valid for the cycle following each accepted pop.
    always_ff @(posedge clk) begin
        if (clr) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pop_acc;
        end
    end

    // Sticky rejection flags, cleared only by reset or flush.
    always_ff @(posedge clk) begin
        if (clr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow  | push_rej;
            underflow <= underflow | pop_rej;
        end
    end

endmodule
